// File: rtl/and_or_sweep_checker.sv
// Exhaustive on-chip checker for a 4-input combinational block: steps stim through 0..15,
// samples resp at the end of each settle window and accumulates pass/fail results.
module and_or_sweep_checker #(
    parameter int unsigned SETTLE     = 5,
    parameter logic [15:0] EXPECT_LUT = 16'hF888
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [3:0] stim,
    input  logic       resp,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_count,
    output logic       first_err_valid,
    output logic [3:0] first_err_vec
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(SETTLE - 1);

    state_t     state;
    state_t     state_next;
    logic [3:0] vec;
    logic [7:0] cnt;
    logic       sample;
    logic       mismatch;
    logic [4:0] err_next;

    assign stim     = vec;
    assign sample   = (state == RUN) && (cnt == LAST_CNT);
    assign mismatch = (resp != EXPECT_LUT[vec]);
    assign err_next = err_count + {4'd0, mismatch};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (sample && (vec == 4'hF)) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Results only move on a start edge or a sample edge; everything else holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            vec             <= 4'd0;
            cnt             <= 8'd0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= 5'd0;
            first_err_valid <= 1'b0;
            first_err_vec   <= 4'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        vec             <= 4'd0;
                        cnt             <= 8'd0;
                        busy            <= 1'b1;
                        done            <= 1'b0;
                        pass            <= 1'b0;
                        err_count       <= 5'd0;
                        first_err_valid <= 1'b0;
                        first_err_vec   <= 4'd0;
                    end
                end
                RUN: begin
                    if (sample) begin
                        err_count <= err_next;
                        if (mismatch && !first_err_valid) begin
                            first_err_valid <= 1'b1;
                            first_err_vec   <= vec;
                        end
                        if (vec != 4'hF) begin
                            vec <= vec + 4'd1;
                            cnt <= 8'd0;
                        end else begin
                            busy <= 1'b0;
                            done <= 1'b1;
                            pass <= (err_next == 5'd0);
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    busy <= 1'b0;
                    done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_and_or_sweep_checker.sv
// Scoreboard bench: two checker instances (SETTLE=5 and SETTLE=1) driven by selectable
// behavioural models of the AND_OR block; a monitor per instance checks stepping and results.
module tb_and_or_sweep_checker;

    typedef struct {
        logic       pass;
        logic [4:0] errs;
        logic       fv;
        logic [3:0] fvec;
        int         cycles;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start5 = 1'b0;
    logic start1 = 1'b0;
    int   mode5 = 0;
    int   mode1 = 0;

    logic [3:0] stim5, stim1, fvec5, fvec1;
    logic       resp5, resp1, busy5, busy1, done5, done1, pass5, pass1, fv5, fv1;
    logic [4:0] err5, err1;
    logic       late_q = 1'b0;

    int applied = 0;
    int miscompares = 0;

    exp_t q5[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    function automatic logic and_or(input logic [3:0] v);
        return (v[0] & v[1]) | (v[2] & v[3]);
    endfunction

    function automatic exp_t mkExp(input logic p, input logic [4:0] e, input logic f,
                                   input logic [3:0] fv, input int c);
        exp_t x;
        x.pass = p; x.errs = e; x.fv = f; x.fvec = fv; x.cycles = c;
        return x;
    endfunction

    // mode5: 0 correct, 1 tied low, 2 tied high, 3 inverted
    always_comb begin
        resp5 = and_or(stim5);
        case (mode5)
            1:       resp5 = 1'b0;
            2:       resp5 = 1'b1;
            3:       resp5 = ~and_or(stim5);
            default: resp5 = and_or(stim5);
        endcase
    end

    // mode1: 0 correct, 1 output registered one cycle late
    always @(posedge clk) late_q <= and_or(stim1);

    always_comb begin
        resp1 = and_or(stim1);
        if (mode1 == 1) resp1 = late_q;
    end

    and_or_sweep_checker #(.SETTLE(5), .EXPECT_LUT(16'hF888)) dut5 (
        .clk(clk), .rst(rst), .start(start5), .stim(stim5), .resp(resp5),
        .busy(busy5), .done(done5), .pass(pass5), .err_count(err5),
        .first_err_valid(fv5), .first_err_vec(fvec5)
    );

    and_or_sweep_checker #(.SETTLE(1), .EXPECT_LUT(16'hF888)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .stim(stim1), .resp(resp1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .first_err_valid(fv1), .first_err_vec(fvec1)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        applied++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic failNow(input string name);
        applied++;
        miscompares++;
        $display("[TB] FAIL %s: bound expired at %0t", name, $time);
    endtask

    task automatic checkResetVals(input string tag, input logic [3:0] s, input logic b,
                                  input logic d, input logic p, input logic [4:0] e,
                                  input logic f, input logic [3:0] fv);
        checkOutput({tag, "_stim"}, s, 0);
        checkOutput({tag, "_busy"}, b, 0);
        checkOutput({tag, "_done"}, d, 0);
        checkOutput({tag, "_pass"}, p, 0);
        checkOutput({tag, "_err"}, e, 0);
        checkOutput({tag, "_fvalid"}, f, 0);
        checkOutput({tag, "_fvec"}, fv, 0);
    endtask

    // Issue a start (held for 'hold' cycles), queue the expected result, and check the
    // state right after the start edge: busy up, everything else cleared.
    task automatic applyStimulus(input bit fast, input int mode, input exp_t e, input int hold);
        @(negedge clk);
        if (fast) begin
            mode1 = mode; q1.push_back(e); start1 = 1'b1;
        end else begin
            mode5 = mode; q5.push_back(e); start5 = 1'b1;
        end
        @(negedge clk);
        if (fast) begin
            checkOutput("start1_busy", busy1, 1);
            checkOutput("start1_done", done1, 0);
            checkOutput("start1_err", err1, 0);
            checkOutput("start1_fvalid", fv1, 0);
            checkOutput("start1_stim", stim1, 0);
        end else begin
            checkOutput("start5_busy", busy5, 1);
            checkOutput("start5_done", done5, 0);
            checkOutput("start5_err", err5, 0);
            checkOutput("start5_fvalid", fv5, 0);
            checkOutput("start5_fvec", fvec5, 0);
            checkOutput("start5_stim", stim5, 0);
        end
        repeat (hold - 1) @(negedge clk);
        start5 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic waitDone(input bit fast, input int limit);
        int n;
        n = 0;
        while (((fast ? done1 : done5) !== 1'b1) && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (n >= limit) failNow(fast ? "wait_done1" : "wait_done5");
    endtask

    // Monitors: stim must step once per SETTLE busy cycles; on each done rising edge the
    // oldest queued expectation is popped and compared, including the busy length.
    int   bcnt5 = 0, bcnt1 = 0;
    logic busy5_q = 1'b0, busy1_q = 1'b0, done5_q = 1'b0, done1_q = 1'b0;

    always @(negedge clk) begin
        exp_t x;
        if (busy5) begin
            if (!busy5_q) bcnt5 = 0;
            bcnt5++;
            checkOutput("stim5_step", stim5, (bcnt5 - 1) / 5);
        end
        if (done5 && !done5_q) begin
            if (q5.size() == 0) begin
                failNow("dut5_unexpected_done");
            end else begin
                x = q5.pop_front();
                checkOutput("dut5_pass", pass5, x.pass);
                checkOutput("dut5_err_count", err5, x.errs);
                checkOutput("dut5_first_valid", fv5, x.fv);
                checkOutput("dut5_first_vec", fvec5, x.fvec);
                checkOutput("dut5_busy_cycles", bcnt5, x.cycles);
            end
        end
        busy5_q = busy5;
        done5_q = done5;
    end

    always @(negedge clk) begin
        exp_t x;
        if (busy1) begin
            if (!busy1_q) bcnt1 = 0;
            bcnt1++;
            checkOutput("stim1_step", stim1, bcnt1 - 1);
        end
        if (done1 && !done1_q) begin
            if (q1.size() == 0) begin
                failNow("dut1_unexpected_done");
            end else begin
                x = q1.pop_front();
                checkOutput("dut1_pass", pass1, x.pass);
                checkOutput("dut1_err_count", err1, x.errs);
                checkOutput("dut1_first_valid", fv1, x.fv);
                checkOutput("dut1_first_vec", fvec1, x.fvec);
                checkOutput("dut1_busy_cycles", bcnt1, x.cycles);
            end
        end
        busy1_q = busy1;
        done1_q = done1;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkResetVals("rst5", stim5, busy5, done5, pass5, err5, fv5, fvec5);
        checkResetVals("rst1", stim1, busy1, done1, pass1, err1, fv1, fvec1);
        rst = 1'b0;

        // LUT F888 has ones at 3,7,11..15: tied-low misses 7, tied-high misses 9.
        applyStimulus(0, 0, mkExp(1'b1, 5'd0, 1'b0, 4'd0, 80), 1);
        waitDone(0, 100);
        applyStimulus(0, 1, mkExp(1'b0, 5'd7, 1'b1, 4'd3, 80), 1);
        waitDone(0, 100);
        applyStimulus(0, 2, mkExp(1'b0, 5'd9, 1'b1, 4'd0, 80), 1);
        waitDone(0, 100);
        applyStimulus(0, 3, mkExp(1'b0, 5'd16, 1'b1, 4'd0, 80), 1);
        waitDone(0, 100);

        // Abort mid-sweep with rst while stim=6; no result is queued for this sweep.
        @(negedge clk);
        mode5 = 0;
        start5 = 1'b1;
        @(negedge clk);
        start5 = 1'b0;
        n = 0;
        while (stim5 != 4'd6 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) failNow("wait_stim6");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkResetVals("midrst5", stim5, busy5, done5, pass5, err5, fv5, fvec5);
        applyStimulus(0, 0, mkExp(1'b1, 5'd0, 1'b0, 4'd0, 80), 1);
        waitDone(0, 100);

        // Start held for 20 cycles must not restart; then restart from DONE with tied-low.
        applyStimulus(0, 2, mkExp(1'b0, 5'd9, 1'b1, 4'd0, 80), 20);
        waitDone(0, 100);
        applyStimulus(0, 1, mkExp(1'b0, 5'd7, 1'b1, 4'd3, 80), 1);
        waitDone(0, 100);

        // SETTLE=1: late model sees f(i-1) at vector i; f steps at 3,4,7,8,11 -> 5 errors.
        applyStimulus(1, 1, mkExp(1'b0, 5'd5, 1'b1, 4'd3, 16), 1);
        waitDone(1, 40);
        applyStimulus(1, 0, mkExp(1'b1, 5'd0, 1'b0, 4'd0, 16), 1);
        waitDone(1, 40);

        repeat (3) @(negedge clk);
        checkOutput("queue5_drained", q5.size(), 0);
        checkOutput("queue1_drained", q1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
